// File: rtl/display_seq_pkg.sv
// display_seq_pkg
// Shared definitions for the display sequencer slice.
//   SEL_A / SEL_B / SEL_OP / SEL_ALU : view codes driven onto the selector
//   op_state_e                      : operation FSM states (ST_IDLE, ST_WAIT)
//   next_view()                     : rotation order of the views in auto mode
package display_seq_pkg;

  localparam logic [1:0] SEL_A   = 2'b00;
  localparam logic [1:0] SEL_B   = 2'b01;
  localparam logic [1:0] SEL_OP  = 2'b10;
  localparam logic [1:0] SEL_ALU = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } op_state_e;

  // The two-bit code wraps naturally from SEL_ALU back to SEL_A.
  function automatic logic [1:0] next_view(input logic [1:0] view);
    return view + 2'd1;
  endfunction

endpackage

// File: rtl/display_sequencer_if.sv
// display_sequencer_if
// Bundles the signals between the sequencer and the selector/ALU pair.
//   A, B, opCodeA : registered operands and opcode presented to the ALU
//   alu_y         : combinational ALU result returned to the sequencer
//   result        : captured ALU result shown on the result view
//   select        : view code for the LED selector
//   busy, done    : operation status and one-cycle capture pulse
// Modports: master = sequencer side, slave = selector/ALU side.
interface display_sequencer_if;

  logic [3:0] A;
  logic [3:0] B;
  logic [2:0] opCodeA;
  logic [7:0] alu_y;
  logic [7:0] result;
  logic [1:0] select;
  logic       busy;
  logic       done;

  modport master (
    output A, B, opCodeA, result, select, busy, done,
    input  alu_y
  );

  modport slave (
    input  A, B, opCodeA, result, select, busy, done,
    output alu_y
  );

endinterface

// File: rtl/display_sequencer_dwell_timer.sv
// dwell_timer
// Free-running dwell counter counting 0 .. DWELL_CYCLES-1 and wrapping.
//   clk, rst : clock and synchronous active-high reset
//   clear_i  : forces the count back to 0 (highest priority)
//   en_i     : advances the count by one per cycle
//   tc_o     : high while the count sits on its last value
module dwell_timer #(
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int W = $clog2(DWELL_CYCLES);
  localparam logic [W-1:0] LAST = W'(DWELL_CYCLES - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign tc_o = (count_q == LAST);

  // Clear beats enable so a new hold or a manual-mode cycle always
  // starts the next dwell from a clean zero.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = tc_o ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/display_sequencer.sv
// display_sequencer
// Captures switch operands on a go request, holds them stable for the ALU
// for ALU_LAT cycles, captures the 8-bit ALU result and drives the LED
// selector view code (auto rotation, manual code, or post-capture hold).
//
// Ports:
//   clk, rst           : clock and synchronous active-high reset
//   sw_a, sw_b, sw_op  : raw operand / opcode switches
//   go                 : operation request
//   auto_en            : 1 = rotate views, 0 = follow man_sel
//   man_sel            : manual view code
//   bus (master)       : A, B, opCodeA, result, select, busy, done out;
//                        alu_y in
//
// Build option: define DISPLAY_SEQ_GO_EDGE_EN to pass go through a rising
// edge detector so a held level starts exactly one operation. Without it go
// is level-sensitive and retriggers every time the FSM is idle.
module display_sequencer
  import display_seq_pkg::*;
#(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int ALU_LAT      = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [3:0]                 sw_a,
  input  logic [3:0]                 sw_b,
  input  logic [2:0]                 sw_op,
  input  logic                       go,
  input  logic                       auto_en,
  input  logic [1:0]                 man_sel,
  display_sequencer_if.master        bus
);

  localparam int CNT_W = $clog2(ALU_LAT + 1);

  op_state_e        state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [3:0]       a_q,      a_d;
  logic [3:0]       b_q,      b_d;
  logic [2:0]       op_q,     op_d;
  logic [7:0]       result_q, result_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [1:0]       select_q, select_d;
  logic             hold_q,   hold_d;

  logic goAccept;
  logic capture;
  logic timerClear;
  logic timerEn;
  logic dwellTc;

`ifdef DISPLAY_SEQ_GO_EDGE_EN
  logic goPrev_q;

  // Remember last cycle's go so only a 0->1 transition counts as a request.
  always_ff @(posedge clk) begin
    if (rst) begin
      goPrev_q <= 1'b0;
    end else begin
      goPrev_q <= go;
    end
  end

  assign goAccept = go & ~goPrev_q;
`else
  assign goAccept = go;
`endif

  // Operation FSM. Operands only change on the IDLE->WAIT transition, so
  // switch activity mid-operation never reaches the ALU. The capture lands
  // back in IDLE, which is why go on the done cycle is accepted.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    capture  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (goAccept) begin
          a_d     = sw_a;
          b_d     = sw_b;
          op_d    = sw_op;
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(ALU_LAT);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          result_d = bus.alu_y;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          capture  = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // View selection. A capture always wins and (re)starts the result hold.
  // When the hold expires the timer has just wrapped to zero, so auto mode
  // restarts at view A with a full dwell.
  always_comb begin
    select_d = select_q;
    hold_d   = hold_q;
    if (capture) begin
      hold_d   = 1'b1;
      select_d = SEL_ALU;
    end else if (hold_q) begin
      if (dwellTc) begin
        hold_d   = 1'b0;
        select_d = auto_en ? SEL_A : man_sel;
      end
    end else if (auto_en) begin
      if (dwellTc) begin
        select_d = next_view(select_q);
      end
    end else begin
      select_d = man_sel;
    end
  end

  // Manual mode pins the timer at zero, so enabling auto mode always
  // starts with a full dwell on the current view.
  assign timerClear = capture | (~hold_q & ~auto_en);
  assign timerEn    = hold_q | auto_en;

  dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dwell_timer (
    .clk     (clk),
    .rst     (rst),
    .clear_i (timerClear),
    .en_i    (timerEn),
    .tc_o    (dwellTc)
  );

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      select_q <= SEL_A;
      hold_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      select_q <= select_d;
      hold_q   <= hold_d;
    end
  end

  assign bus.A       = a_q;
  assign bus.B       = b_q;
  assign bus.opCodeA = op_q;
  assign bus.result  = result_q;
  assign bus.select  = select_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_display_sequencer.sv
// tb_display_sequencer
// Directed bench for display_sequencer with ALU_LAT=2 and DWELL_CYCLES=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_display_sequencer;

  logic       clk;
  logic       rst;
  logic [3:0] sw_a;
  logic [3:0] sw_b;
  logic [2:0] sw_op;
  logic       go;
  logic       auto_en;
  logic [1:0] man_sel;
  logic       useModel;
  logic [7:0] aluConst;

  int vecCount = 0;
  int errCount = 0;

  display_sequencer_if bus();

  // Stand-in ALU: either a fixed value or {A,B} + opcode.
  assign bus.alu_y = useModel ? ({bus.A, bus.B} + {5'b0, bus.opCodeA}) : aluConst;

  display_sequencer #(
    .DWELL_CYCLES(4),
    .ALU_LAT(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sw_a    (sw_a),
    .sw_b    (sw_b),
    .sw_op   (sw_op),
    .go      (go),
    .auto_en (auto_en),
    .man_sel (man_sel),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vecCount++; if (bus.A !== 4'h0) begin errCount++; $display("[TB] FAIL reset_A got %h want 0", bus.A); end
    vecCount++; if (bus.B !== 4'h0) begin errCount++; $display("[TB] FAIL reset_B got %h want 0", bus.B); end
    vecCount++; if (bus.opCodeA !== 3'h0) begin errCount++; $display("[TB] FAIL reset_op got %h want 0", bus.opCodeA); end
    vecCount++; if (bus.result !== 8'h00) begin errCount++; $display("[TB] FAIL reset_result got %h want 00", bus.result); end
    vecCount++; if (bus.select !== 2'b00) begin errCount++; $display("[TB] FAIL reset_select got %b want 00", bus.select); end
    vecCount++; if (bus.busy !== 1'b0) begin errCount++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
    vecCount++; if (bus.done !== 1'b0) begin errCount++; $display("[TB] FAIL reset_done got %b want 0", bus.done); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_op();
    useModel = 1'b0; aluConst = 8'hF0;
    sw_a = 4'h1; sw_b = 4'h2; sw_op = 3'h7; go = 1'b1;
    tick();
    go = 1'b0;
    vecCount++; if (bus.A !== 4'h1) begin errCount++; $display("[TB] FAIL basic_A got %h want 1", bus.A); end
    vecCount++; if (bus.B !== 4'h2) begin errCount++; $display("[TB] FAIL basic_B got %h want 2", bus.B); end
    vecCount++; if (bus.opCodeA !== 3'h7) begin errCount++; $display("[TB] FAIL basic_op got %h want 7", bus.opCodeA); end
    vecCount++; if (bus.busy !== 1'b1) begin errCount++; $display("[TB] FAIL basic_busy_k got %b want 1", bus.busy); end
    tick();
    vecCount++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin errCount++; $display("[TB] FAIL basic_k1 got done=%b busy=%b want done=0 busy=1", bus.done, bus.busy); end
    tick();
    vecCount++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errCount++; $display("[TB] FAIL basic_done got done=%b busy=%b want done=1 busy=0", bus.done, bus.busy); end
    vecCount++; if (bus.result !== 8'hF0) begin errCount++; $display("[TB] FAIL basic_result got %h want f0", bus.result); end
    vecCount++; if (bus.select !== 2'b11) begin errCount++; $display("[TB] FAIL basic_hold0 got %b want 11", bus.select); end
    for (int i = 1; i < 4; i++) begin
      tick();
      vecCount++; if (bus.select !== 2'b11 || bus.done !== 1'b0) begin errCount++; $display("[TB] FAIL basic_hold%0d got select=%b done=%b want 11/0", i, bus.select, bus.done); end
    end
    tick();
    vecCount++; if (bus.select !== 2'b00) begin errCount++; $display("[TB] FAIL basic_hold_end got %b want 00", bus.select); end
  endtask

  task automatic test_auto();
    logic [1:0] expView;
    auto_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      expView = 2'((i >> 2) & 3);
      vecCount++; if (bus.select !== expView) begin errCount++; $display("[TB] FAIL auto_step%0d got %b want %b", i, bus.select, expView); end
    end
    auto_en = 1'b0;
    tick();
  endtask

  task automatic test_ignore_busy();
    man_sel = 2'b01;
    tick();
    useModel = 1'b1;
    sw_a = 4'h3; sw_b = 4'h5; sw_op = 3'h2; go = 1'b1;
    tick();
    go = 1'b0; sw_a = 4'hF; sw_b = 4'hF; sw_op = 3'h0;
    vecCount++; if (bus.A !== 4'h3) begin errCount++; $display("[TB] FAIL ign_A_k got %h want 3", bus.A); end
    tick();
    vecCount++; if (bus.A !== 4'h3 || bus.busy !== 1'b1) begin errCount++; $display("[TB] FAIL ign_k1 got A=%h busy=%b want 3/1", bus.A, bus.busy); end
    go = 1'b1;
    tick();
    go = 1'b0;
    vecCount++; if (bus.done !== 1'b1) begin errCount++; $display("[TB] FAIL ign_done got %b want 1", bus.done); end
    vecCount++; if (bus.result !== 8'h37) begin errCount++; $display("[TB] FAIL ign_result got %h want 37", bus.result); end
    vecCount++; if ({bus.A, bus.B, bus.opCodeA} !== {4'h3, 4'h5, 3'h2}) begin errCount++; $display("[TB] FAIL ign_operands got %h/%h/%h want 3/5/2", bus.A, bus.B, bus.opCodeA); end
    tick();
    vecCount++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errCount++; $display("[TB] FAIL ign_no_queue got done=%b busy=%b want 0/0", bus.done, bus.busy); end
    tick(); tick(); tick();
    vecCount++; if (bus.select !== 2'b01) begin errCount++; $display("[TB] FAIL ign_hold_end got %b want 01", bus.select); end
  endtask

  task automatic test_manual();
    man_sel = 2'b10;
    vecCount++; if (bus.select !== 2'b01) begin errCount++; $display("[TB] FAIL man_latency got %b want 01", bus.select); end
    tick();
    vecCount++; if (bus.select !== 2'b10) begin errCount++; $display("[TB] FAIL man_10 got %b want 10", bus.select); end
    man_sel = 2'b01;
    tick();
    vecCount++; if (bus.select !== 2'b01) begin errCount++; $display("[TB] FAIL man_01 got %b want 01", bus.select); end
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    tick();
    vecCount++; if (bus.done !== 1'b1 || bus.result !== 8'hFF) begin errCount++; $display("[TB] FAIL man_capture got done=%b result=%h want 1/ff", bus.done, bus.result); end
    vecCount++; if (bus.select !== 2'b11) begin errCount++; $display("[TB] FAIL man_hold0 got %b want 11", bus.select); end
    for (int i = 1; i < 4; i++) begin
      tick();
      vecCount++; if (bus.select !== 2'b11) begin errCount++; $display("[TB] FAIL man_hold%0d got %b want 11", i, bus.select); end
    end
    tick();
    vecCount++; if (bus.select !== 2'b01) begin errCount++; $display("[TB] FAIL man_resume got %b want 01", bus.select); end
  endtask

  task automatic test_reset_mid_wait();
    man_sel = 2'b00;
    sw_a = 4'h1; sw_b = 4'h2; sw_op = 3'h3; go = 1'b1;
    tick();
    go = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vecCount++; if ({bus.A, bus.B, bus.opCodeA} !== 11'h0) begin errCount++; $display("[TB] FAIL rmw_operands got %h/%h/%h want 0/0/0", bus.A, bus.B, bus.opCodeA); end
    vecCount++; if (bus.result !== 8'h00 || bus.select !== 2'b00) begin errCount++; $display("[TB] FAIL rmw_outputs got result=%h select=%b want 00/00", bus.result, bus.select); end
    vecCount++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errCount++; $display("[TB] FAIL rmw_status got busy=%b done=%b want 0/0", bus.busy, bus.done); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vecCount++; if (bus.done !== 1'b0) begin errCount++; $display("[TB] FAIL rmw_no_done%0d got %b want 0", i, bus.done); end
    end
    sw_a = 4'h4; sw_b = 4'h1; sw_op = 3'h1; go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    tick();
    vecCount++; if (bus.done !== 1'b1 || bus.result !== 8'h42) begin errCount++; $display("[TB] FAIL rmw_next_op got done=%b result=%h want 1/42", bus.done, bus.result); end
  endtask

  task automatic test_go_held();
    int doneCount;
    int expCount;
    doneCount = 0;
`ifdef DISPLAY_SEQ_GO_EDGE_EN
    expCount = 1;
`else
    expCount = 4;
`endif
    tick();
    go = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i == 10) go = 1'b0;
      if (i == 3) begin
        vecCount++; if (bus.done !== 1'b1) begin errCount++; $display("[TB] FAIL held_first_done got %b want 1", bus.done); end
      end
      if (bus.done === 1'b1) doneCount++;
    end
    vecCount++; if (doneCount !== expCount) begin errCount++; $display("[TB] FAIL held_done_count got %0d want %0d", doneCount, expCount); end
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; auto_en = 1'b0; man_sel = 2'b00;
    sw_a = 4'h0; sw_b = 4'h0; sw_op = 3'h0;
    useModel = 1'b0; aluConst = 8'h00;
    test_reset();
    test_basic_op();
    test_auto();
    test_ignore_busy();
    test_manual();
    test_reset_mid_wait();
    test_go_held();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule

// File: doc/display_sequencer.md
# display_sequencer

Controller for the LED output selector on the Spartan test board. Captures switch operands on a `go` request, presents them to the ALU, waits a fixed ALU latency, captures the 8-bit result, and drives the selector's `select` code. The code either rotates automatically through the four views on a dwell timer or follows a manual code, and is forced to the result view after each capture. Sits between the board switches/buttons and the `selector`/ALU pair.

## Interface
Parameters:
- `DWELL_CYCLES`, 50_000_000: cycles each view is shown in auto mode and during post-capture hold; must be ≥ 2.
- `ALU_LAT`, 1: cycles the operands are held stable before `alu_y` is sampled; must be ≥ 1.

Ports:
- `clk`  in  1  sole clock
- `rst`  in  1  reset, synchronous, active-high
- `sw_a`  in  4  raw operand A switches
- `sw_b`  in  4  raw operand B switches
- `sw_op`  in  3  raw opcode switches
- `go`  in  1  operation request
- `auto_en`  in  1  1 = rotate views, 0 = follow `man_sel`
- `man_sel`  in  2  manual view code
- `alu_y`  in  8  ALU result (combinational from `A`, `B`, `opCodeA`)
- `A`  out  4  registered operand A to ALU/selector
- `B`  out  4  registered operand B
- `opCodeA`  out  3  registered opcode
- `result`  out  8  captured ALU result
- `select`  out  2  view code to selector (registered)
- `busy`  out  1  operation in flight
- `done`  out  1  one-cycle pulse on capture

## Operation
- View codes: 00 = A, 01 = B, 10 = opcode, 11 = ALU result.
- Operation FSM, states IDLE and WAIT:
  - IDLE with go accepted: load `A`/`B`/`opCodeA` from switches, `busy` <= 1, cnt <= `ALU_LAT`, go to WAIT.
  - WAIT with cnt > 1: cnt decrements.
  - WAIT with cnt == 1: `result` <= `alu_y`, `done` <= 1, `busy` <= 0, start hold, go to IDLE.
- `go` in WAIT is ignored and is not queued. `go` in the cycle `done` is high is accepted, because the FSM is already in IDLE.
- Operands stay unchanged outside the IDLE→WAIT transition. Switch changes mid-operation have no effect.
- View control, in priority order:
  1. Hold: `select` = 11 for `DWELL_CYCLES` cycles after capture. After the hold, auto mode resumes at 00 and manual mode resumes following `man_sel`.
  2. Auto (`auto_en` = 1): `select` advances +1 mod 4 each time the dwell counter reaches `DWELL_CYCLES`-1. The counter then wraps to 0.
  3. Manual: `select` <= `man_sel` every cycle, and the dwell counter is held at 0.
- A capture during an active hold restarts the hold.
- When `auto_en` rises outside a hold, the first advance happens after a full dwell.
- Rotation continues while `busy`.
- Reset values: `select` 00, `A`/`B`/`opCodeA` 0, `result` 0, `busy` 0, `done` 0, FSM IDLE, dwell counter 0, hold inactive. Reset mid-WAIT abandons the operation without a `done` pulse.

## Timing
- If edge k accepts `go`: outputs change after k, and `busy` is high from cycle k+1.
- `alu_y` is sampled at edge k+`ALU_LAT`. `done` is high and `busy` is low for the one cycle following that edge. `result` and `select`=11 are valid in the same cycle as `done`.
- Manual `select` follows `man_sel` with 1-cycle latency.
- Auto mode: each view lasts exactly `DWELL_CYCLES` cycles.

## Configuration
- `DISPLAY_SEQ_GO_EDGE_EN` defined: `go` passes through an internal rising-edge detector (one register). A level held high starts exactly one operation.
- `DISPLAY_SEQ_GO_EDGE_EN` undefined: `go` is level-sensitive. Holding it high retriggers an operation every time the FSM is in IDLE, i.e. on the `done` cycle.

## Structure
- Package `display_seq_pkg`:
  - view code constants `SEL_A`, `SEL_B`, `SEL_OP`, `SEL_ALU`
  - FSM state typedef (`ST_IDLE`, `ST_WAIT`)
- Sub-module `dwell_timer`:
  - `$clog2(DWELL_CYCLES)`-bit counter with clear, enable and terminal-count output
  - used for both rotation and hold

## Test plan
All scenarios use `ALU_LAT`=2 and `DWELL_CYCLES`=4.
- Reset mid-WAIT, `rst` held 1 cycle → all outputs 0, no `done`, and the next `go` starts a normal operation.
- `sw_a`=0001, `sw_b`=0010, `sw_op`=111, `go` pulse, `alu_y`=F0 → `A`=1, `B`=2, `opCodeA`=7 after edge k; `done`=1 and `result`=F0 after edge k+2; `select`=11 for 4 cycles.
- `auto_en`=1, no `go` → `select` sequence 00,01,10,11,00 with exactly 4 cycles per view.
- Second `go` while `busy`, or switch change during WAIT → ignored; `result` reflects the original operands.
- `auto_en`=0, `man_sel`=10 then 01 → `select` follows with 1-cycle latency. After a capture, `select` is 11 for 4 cycles, then returns to `man_sel`.
- `go` held high for 10 cycles → with `DISPLAY_SEQ_GO_EDGE_EN`, exactly one `done`; without it, `done` every 3 cycles.
